// File: rtl/ra_controller.sv
// ra_controller: walks spare-allocation candidates through the analyzer until the first cover; RA_CTRL_TIMEOUT_EN adds a per-candidate WAIT timeout
module ra_controller #(
  parameter int NUM_CAND = 32,
  parameter int IDX_W = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             must_fail,
  output logic             cand_valid,
  input  logic             cand_ready,
  output logic [IDX_W-1:0] cand_idx,
  input  logic             res_valid,
  input  logic             res_pass,
  input  logic [15:0]      res_addr,
  output logic             busy,
  output logic             done,
  output logic             repairable,
  output logic [15:0]      repair_addr,
  output logic [IDX_W:0]   tried_count,
  output logic             timeout_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CAND - 1);
  state_t state;
  logic expired;
`ifdef RA_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;
  assign expired = tcnt == TW'(TIMEOUT - 1);
`else
  assign expired = 1'b0;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cand_valid <= 1'b0;
      cand_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      repairable <= 1'b0;
      repair_addr <= '0;
      tried_count <= '0;
`ifdef RA_CTRL_TIMEOUT_EN
      tcnt <= '0;
      timeout_err <= 1'b0;
`endif
    end else if (abort) begin
      state <= IDLE;
      busy <= 1'b0;
      cand_valid <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cand_idx <= '0;
          tried_count <= '0;
          repairable <= 1'b0;
          repair_addr <= '0;
          busy <= 1'b1;
`ifdef RA_CTRL_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
          state <= must_fail ? DONE : ISSUE;
          done <= must_fail;
          cand_valid <= !must_fail;
        end
        ISSUE: if (cand_ready) begin
          state <= WAIT;
          cand_valid <= 1'b0;
`ifdef RA_CTRL_TIMEOUT_EN
          tcnt <= '0;
`endif
        end
        WAIT: if (res_valid || expired) begin
          tried_count <= tried_count + 1'b1;
`ifdef RA_CTRL_TIMEOUT_EN
          if (!res_valid) timeout_err <= 1'b1;
`endif
          if (res_valid && res_pass) begin
            repair_addr <= res_addr;
            repairable <= 1'b1;
            state <= DONE;
            done <= 1'b1;
          end else if (cand_idx == LAST) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            cand_idx <= cand_idx + 1'b1;
            state <= ISSUE;
            cand_valid <= 1'b1;
          end
        end
`ifdef RA_CTRL_TIMEOUT_EN
        else tcnt <= tcnt + 1'b1;
`endif
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
